// File: rtl/error_check.sv
`timescale 1ns/1ps
// UART frame checker: flags parity, start-bit and stop-bit errors on each received frame.
// Latency: error_flag updates on the rising edge where recieved_flag is high, held otherwise.
// Backpressure: none; the strobe is accepted unconditionally on every cycle it is high.
module error_check (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] data,
    input  logic       start_bit,
    input  logic       stop_bit,
    input  logic       parity_bit,
    input  logic [1:0] parity_type,
    input  logic       recieved_flag,
    output logic [2:0] error_flag
);

    localparam logic [1:0] PAR_ODD  = 2'b01;
    localparam logic [1:0] PAR_EVEN = 2'b10;

    logic [2:0] error_flag_q;
    logic [2:0] error_flag_d;
    logic       par_sum;
    logic       par_err;
    logic       start_err;
    logic       stop_err;

    always_comb begin
        par_sum   = (^data) ^ parity_bit;
        par_err   = 1'b0;
        start_err = start_bit;
        stop_err  = ~stop_bit;
        // Modes 00 and 11 both disable the parity check.
        case (parity_type)
            PAR_ODD:  par_err = ~par_sum;
            PAR_EVEN: par_err = par_sum;
            default:  par_err = 1'b0;
        endcase
    end

    always_comb begin
        error_flag_d = error_flag_q;
        if (recieved_flag) begin
            error_flag_d = {stop_err, start_err, par_err};
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            error_flag_q <= 3'b000;
        end else begin
            error_flag_q <= error_flag_d;
        end
    end

    assign error_flag = error_flag_q;

endmodule

// File: tb/tb_error_check.sv
`timescale 1ns/1ps
// Scoreboard bench for error_check: stimulus pushes expected flags, a monitor pops them after each strobe edge.
module tb_error_check;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [7:0] data = 8'h00;
    logic       start_bit = 1'b1;
    logic       stop_bit = 1'b0;
    logic       parity_bit = 1'b1;
    logic [1:0] parity_type = 2'b10;
    logic       recieved_flag = 1'b1;
    logic [2:0] error_flag;

    int tests_run = 0;
    int tests_failed = 0;

    logic [2:0] exp_q[$];
    logic [2:0] last_exp = 3'b000;
    logic       strobe_seen = 1'b0;

    error_check dut (
        .clk           (clk),
        .rst           (rst),
        .data          (data),
        .start_bit     (start_bit),
        .stop_bit      (stop_bit),
        .parity_bit    (parity_bit),
        .parity_type   (parity_type),
        .recieved_flag (recieved_flag),
        .error_flag    (error_flag)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [2:0] act, input logic [2:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %b, expected %b at %0t", name, act, exp, $time);
        end
    endtask

    // Independent reference: count ones rather than XOR-reduce.
    function automatic logic [2:0] model(input logic [7:0] d, input logic s, input logic st,
                                         input logic pb, input logic [1:0] pt);
        int ones = 0;
        logic par = 1'b0;
        for (int i = 0; i < 8; i++) ones += int'(d[i]);
        if (pt == 2'b01) par = ((ones % 2 == 1) != (pb == 1'b1)) ? 1'b0 : 1'b1;
        else if (pt == 2'b10) par = ((ones % 2 == 1) != (pb == 1'b1)) ? 1'b1 : 1'b0;
        return {(st == 1'b0), (s == 1'b1), par};
    endfunction

    always @(posedge clk) strobe_seen = recieved_flag & rst;

    always @(negedge clk) begin
        if (!rst) begin
            check("reset_hold", error_flag, 3'b000);
            last_exp = 3'b000;
        end else if (strobe_seen) begin
            if (exp_q.size() == 0) begin
                check("unexpected_strobe", error_flag, 3'bxxx);
            end else begin
                last_exp = exp_q.pop_front();
                check("frame", error_flag, last_exp);
            end
        end else begin
            check("hold", error_flag, last_exp);
        end
    end

    // Drives one cycle of inputs; inputs change 2 time units after the rising edge.
    task automatic drive(input logic [7:0] d, input logic s, input logic st, input logic pb,
                         input logic [1:0] pt, input logic flag, input logic [2:0] exp);
        data = d;
        start_bit = s;
        stop_bit = st;
        parity_bit = pb;
        parity_type = pt;
        recieved_flag = flag;
        if (flag && rst) exp_q.push_back(exp);
        @(posedge clk);
        #2;
    endtask

    initial begin
        logic [7:0] rd;
        logic       rs, rst_b, rpb, rf;
        logic [1:0] rpt;

        @(posedge clk);
        #2;
        // Reset with strobe high and every field bad.
        repeat (4) drive(8'hFF, 1'b1, 1'b0, 1'b1, 2'b10, 1'b1, 3'b000);
        rst = 1'b1;
        repeat (3) drive(8'hFF, 1'b1, 1'b0, 1'b1, 2'b10, 1'b0, 3'b000);

        drive(8'hA5, 1'b0, 1'b1, 1'b0, 2'b10, 1'b1, 3'b000);
        drive(8'hA5, 1'b0, 1'b1, 1'b0, 2'b10, 1'b0, 3'b000);
        drive(8'hA5, 1'b0, 1'b1, 1'b1, 2'b10, 1'b1, 3'b001);
        drive(8'hA5, 1'b0, 1'b1, 1'b1, 2'b10, 1'b0, 3'b000);
        drive(8'hA5, 1'b0, 1'b1, 1'b1, 2'b01, 1'b1, 3'b000);
        drive(8'hA5, 1'b0, 1'b1, 1'b0, 2'b01, 1'b1, 3'b001);
        drive(8'h07, 1'b0, 1'b1, 1'b0, 2'b01, 1'b1, 3'b000);
        drive(8'h07, 1'b0, 1'b1, 1'b0, 2'b01, 1'b0, 3'b000);
        drive(8'h3C, 1'b1, 1'b0, 1'b1, 2'b00, 1'b1, 3'b110);
        drive(8'h3C, 1'b1, 1'b0, 1'b0, 2'b11, 1'b1, 3'b110);
        drive(8'h00, 1'b0, 1'b1, 1'b1, 2'b11, 1'b0, 3'b000);
        drive(8'hA5, 1'b1, 1'b0, 1'b1, 2'b10, 1'b1, 3'b111);
        repeat (10) drive(8'hA5, 1'b0, 1'b1, 1'b0, 2'b10, 1'b0, 3'b000);
        drive(8'hA5, 1'b0, 1'b1, 1'b0, 2'b10, 1'b1, 3'b000);
        drive(8'hA5, 1'b0, 1'b1, 1'b0, 2'b10, 1'b0, 3'b000);
        // Mode change takes effect on the next sampled frame only.
        drive(8'h01, 1'b0, 1'b1, 1'b1, 2'b10, 1'b1, 3'b000);
        drive(8'h01, 1'b0, 1'b1, 1'b1, 2'b01, 1'b1, 3'b001);
        drive(8'h01, 1'b1, 1'b1, 1'b1, 2'b01, 1'b1, 3'b011);
        drive(8'h01, 1'b1, 1'b0, 1'b0, 2'b00, 1'b1, 3'b110);
        drive(8'h01, 1'b1, 1'b0, 1'b0, 2'b00, 1'b0, 3'b000);

        drive(8'hA5, 1'b1, 1'b0, 1'b1, 2'b10, 1'b1, 3'b111);
        drive(8'hA5, 1'b1, 1'b0, 1'b1, 2'b10, 1'b0, 3'b000);
        // Asynchronous reset mid-cycle clears the register without a clock edge.
        #1 rst = 1'b0;
        #1 check("async_reset", error_flag, 3'b000);
        @(posedge clk);
        #2 rst = 1'b1;
        drive(8'h00, 1'b0, 1'b1, 1'b0, 2'b00, 1'b0, 3'b000);

        for (int n = 0; n < 50; n++) begin
            rd = 8'($urandom_range(0, 255));
            rs = 1'($urandom_range(0, 1));
            rst_b = 1'($urandom_range(0, 1));
            rpb = 1'($urandom_range(0, 1));
            rpt = 2'($urandom_range(0, 3));
            rf = 1'($urandom_range(0, 1));
            drive(rd, rs, rst_b, rpb, rpt, rf, model(rd, rs, rst_b, rpb, rpt));
            repeat (99) drive(rd, rs, rst_b, rpb, rpt, 1'b0, 3'b000);
        end

        repeat (2) @(posedge clk);
        tests_run++;
        if (exp_q.size() != 0) begin
            tests_failed++;
            $display("FAIL scoreboard_drain: %0d entries left, expected 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/error_check.md
# error_check

Error checker for the UART receiver datapath. When the receiver asserts its frame-received strobe, the block checks the captured frame fields: start bit, stop bit, and the parity bit against the 8 data bits under the configured parity mode. It then registers a 3-bit error vector for the downstream status/control logic. It holds no data itself and passes no data through.

## Interface

Parameters: none (data width fixed at 8 bits).

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-low reset.
- data  input  8  received data byte, bit 0 first on the line.
- start_bit  input  1  sampled start bit of the frame; must be 0.
- stop_bit  input  1  sampled stop bit of the frame; must be 1.
- parity_bit  input  1  sampled parity bit of the frame.
- parity_type  input  2  parity mode: 2'b00 none, 2'b01 odd, 2'b10 even, 2'b11 none.
- recieved_flag  input  1  frame-complete strobe; frame fields valid while high.
- error_flag  output  3  registered error vector:
  - [0] parity error
  - [1] start-bit error
  - [2] stop-bit error

## Operation

- All inputs are treated as synchronous to clk and are sampled only on rising edges where recieved_flag=1.
- Parity check (combinational, used only at sample time), with p = XOR-reduction of data:
  - Odd mode: error when (p ^ parity_bit) != 1.
  - Even mode: error when (p ^ parity_bit) != 0.
  - None modes (00, 11): parity error forced to 0; parity_bit ignored.
- Start check: error when start_bit != 0.
- Stop check: error when stop_bit != 1.
- On a sampling edge, all three bits of error_flag are overwritten together with the new results. No bit is sticky across frames.
- When recieved_flag=0, error_flag holds its last value.
- Any combination of the three errors may be set simultaneously.
- parity_type is sampled on the same edge as the data. A mode change takes effect only on the next sampled frame.

## Timing

- Reset: rst=0 forces error_flag=3'b000 immediately, asynchronously and regardless of clk. Outputs stay at zero while rst=0. Release is synchronous in effect: the first update happens on the first rising edge with rst=1 and recieved_flag=1.
- Latency: error_flag reflects a frame one edge after sampling. Results are visible right after the rising edge where recieved_flag=1, and hold at least until the next such edge.
- recieved_flag held high for N consecutive edges: the block re-evaluates on every one of those edges, so error_flag tracks the current inputs each cycle.
- Reset asserted during an evaluation edge: reset wins and error_flag=0.
- No internal state other than the 3-bit output register.

## Test plan

- Reset: rst=0 with recieved_flag=1 and bad inputs → error_flag=3'b000 throughout. Release rst with recieved_flag=0 → error_flag stays 3'b000.
- Clean frame, even mode:
  - data=8'hA5, parity_type=2'b10, parity_bit=0, start_bit=0, stop_bit=1, recieved_flag pulsed 1 cycle → error_flag=3'b000.
  - Same frame with parity_bit=1 → 3'b001.
- Odd mode: data=8'hA5, parity_type=2'b01.
  - parity_bit=1 → bit0=0.
  - parity_bit=0 → bit0=1.
  - data=8'h07, parity_bit=0 → bit0=0.
- Framing errors: start_bit=1, stop_bit=0, parity_type=2'b00 with parity_bit arbitrary → error_flag=3'b110. parity_type=2'b11 gives the same result.
- Hold/overwrite:
  - After error_flag=3'b111, drive a clean frame with recieved_flag=0 for 10 cycles → error_flag stays 3'b111.
  - Then pulse recieved_flag → 3'b000.
- Randomized: 50 frames with random data, start, stop, parity, type and strobe, 1000 time units apart. Compare against a reference model after each sampling edge; outputs must hold on non-strobe cycles.
